raifes_dm: RTL and testbench

Debug Module core that consumes the DMI request bus and answers it. It decodes DMI reads and writes into the debug registers dmcontrol, dmstatus, hartinfo, abstractcs, command and data0 (spec 0.13 subset). It drives halt and resume requests to the single hart and runs abstract register-access commands through a request/ack port into the core register file. Sits between the DMI clock-crossing stage, which presents DMI signals synchronous to clk, and the raifes core.

---
 rtl/raifes_dm.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_raifes_dm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/raifes_dm.sv
// raifes_dm: debug module core (0.13 subset).
// Decodes DMI accesses into dmcontrol/dmstatus/hartinfo/abstractcs/command/data0,
// drives halt/resume requests to the single hart and runs abstract GPR accesses.
// Optional: RAIFES_DM_AUTOEXEC_EN adds abstractauto (0x18) with autoexecdata0.
module raifes_dm #(
    parameter logic [31:0] HARTINFO_VAL = 32'h0,
    parameter logic [15:0] GPR_BASE     = 16'h1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  dmi_addr,
    input  logic [31:0] dmi_wdata,
    input  logic        dmi_en,
    input  logic        dmi_wen,
    output logic [31:0] dmi_rdata,
    output logic        dmi_error,
    output logic        dmi_dm_busy,
    output logic        ndmreset,
    output logic        halt_req,
    output logic        resume_req,
    input  logic        hart_halted,
    output logic        dbg_reg_req,
    output logic        dbg_reg_we,
    output logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_wdata,
    input  logic [31:0] dbg_reg_rdata,
    input  logic        dbg_reg_ack
);

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;
`ifdef RAIFES_DM_AUTOEXEC_EN
    localparam logic [6:0] ADDR_ABSTRACTAUTO = 7'h18;
`endif

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BUSY    = 3'd1;
    localparam logic [2:0] ERR_UNSUPP  = 3'd2;
    localparam logic [2:0] ERR_HALTRES = 3'd4;

    typedef enum logic [1:0] {CMD_IDLE, CMD_REQ, CMD_DONE} cmd_state_e;

    cmd_state_e  state_q, state_d;
    logic        dmactive_q, dmactive_d;
    logic        haltreq_q, haltreq_d;
    logic        ndmreset_q, ndmreset_d;
    logic        resume_q, resume_d;
    logic        resumeack_q, resumeack_d;
    logic [31:0] data0_q, data0_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic        cmd_we_q, cmd_we_d;
    logic [4:0]  cmd_regno_q, cmd_regno_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
`ifdef RAIFES_DM_AUTOEXEC_EN
    logic        autoexec_q, autoexec_d;
    logic [31:0] cmd_last_q, cmd_last_d;
    logic        auto_hit;
`endif

    logic        busy;
    logic        cmd_go;
    logic [31:0] cmd_word;
    logic [15:0] regno_off;
    logic        regno_ok;
    logic        cmd_bad;
    logic        run_vis;
    logic        halt_vis;
    logic        cmd_unused;

    assign busy = (state_q == CMD_REQ);

    // Source of the command being decoded: a fresh DMI write, or the last
    // accepted command when a data0 access auto-executes it.
`ifdef RAIFES_DM_AUTOEXEC_EN
    assign auto_hit = autoexec_q && dmi_en && (dmi_addr == ADDR_DATA0) && (state_q == CMD_IDLE);
    assign cmd_word = auto_hit ? cmd_last_q : dmi_wdata;
`else
    assign cmd_word = dmi_wdata;
`endif

    // Reserved / aarpostincrement bits are not interpreted.
    assign cmd_unused = cmd_word[23] ^ cmd_word[19];

    // Command legality: access-register only, 32-bit, no postexec, GPRs only.
    assign regno_off = cmd_word[15:0] - GPR_BASE;
    assign regno_ok  = (cmd_word[15:0] >= GPR_BASE) && (regno_off < 16'd32);
    assign cmd_bad   = (cmd_word[31:24] != 8'd0) || (cmd_word[22:20] != 3'd2) ||
                       cmd_word[18] || (cmd_word[17] && !regno_ok);

    // Hart status is only reported while the DM is active.
    assign run_vis  = dmactive_q & ~hart_halted;
    assign halt_vis = dmactive_q & hart_halted;

    // Next-state: DMI decode, resume handshake, command FSM, dmactive reset hold.
    always_comb begin
        state_d     = state_q;
        dmactive_d  = dmactive_q;
        haltreq_d   = haltreq_q;
        ndmreset_d  = ndmreset_q;
        resume_d    = resume_q;
        resumeack_d = resumeack_q;
        data0_d     = data0_q;
        cmderr_d    = cmderr_q;
        cmd_we_d    = cmd_we_q;
        cmd_regno_d = cmd_regno_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
`ifdef RAIFES_DM_AUTOEXEC_EN
        autoexec_d  = autoexec_q;
        cmd_last_d  = cmd_last_q;
`endif
        cmd_go      = 1'b0;

        // Resume completes once the hart is seen running.
        if (resume_q && !hart_halted) begin
            resume_d    = 1'b0;
            resumeack_d = 1'b1;
        end

        if (dmi_en) begin
            error_d = 1'b0;
            if (!dmi_wen) rdata_d = '0;
            case (dmi_addr)
                ADDR_DATA0: begin
                    // Reads while busy still return the old value but flag cmderr.
                    if (!dmi_wen) rdata_d = data0_q;
                    if (busy) begin
                        if (cmderr_q == ERR_NONE) cmderr_d = ERR_BUSY;
                    end else if (dmi_wen) begin
                        data0_d = dmi_wdata;
                    end
                end
                ADDR_DMCONTROL: begin
                    if (dmi_wen) begin
                        dmactive_d = dmi_wdata[0];
                        ndmreset_d = dmi_wdata[1];
                        haltreq_d  = dmi_wdata[31];
                        // A concurrent haltreq wins over resumereq.
                        if (dmi_wdata[30] && !dmi_wdata[31]) begin
                            resume_d    = 1'b1;
                            resumeack_d = 1'b0;
                        end
                    end else begin
                        rdata_d = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
                    end
                end
                ADDR_DMSTATUS: begin
                    if (!dmi_wen)
                        rdata_d = {14'd0, resumeack_q, resumeack_q, 4'd0,
                                   run_vis, run_vis, halt_vis, halt_vis,
                                   1'b1, 3'd0, 4'd2};
                end
                ADDR_HARTINFO: begin
                    if (!dmi_wen) rdata_d = HARTINFO_VAL;
                end
                ADDR_ABSTRACTCS: begin
                    if (dmi_wen) begin
                        if (busy) begin
                            if (cmderr_q == ERR_NONE) cmderr_d = ERR_BUSY;
                        end else begin
                            cmderr_d = cmderr_q & ~dmi_wdata[10:8];
                        end
                    end else begin
                        rdata_d = {3'd0, 5'd0, 11'd0, busy, 1'b0, cmderr_q, 4'd0, 4'd1};
                    end
                end
                ADDR_COMMAND: begin
                    if (dmi_wen) begin
                        if (busy) begin
                            if (cmderr_q == ERR_NONE) cmderr_d = ERR_BUSY;
                        end else if (state_q == CMD_IDLE) begin
                            cmd_go = 1'b1;
                        end
                    end
                end
`ifdef RAIFES_DM_AUTOEXEC_EN
                ADDR_ABSTRACTAUTO: begin
                    if (dmi_wen) autoexec_d = dmi_wdata[0];
                    else         rdata_d    = {31'd0, autoexec_q};
                end
`endif
                default: error_d = 1'b1;
            endcase
        end

`ifdef RAIFES_DM_AUTOEXEC_EN
        if (auto_hit) cmd_go = 1'b1;
`endif

        // Command acceptance; a sticky cmderr blocks new commands.
        if (cmd_go && (cmderr_q == ERR_NONE)) begin
            cmd_we_d    = cmd_word[16];
            cmd_regno_d = cmd_word[4:0];
`ifdef RAIFES_DM_AUTOEXEC_EN
            cmd_last_d  = cmd_word;
`endif
            if (cmd_bad)           cmderr_d = ERR_UNSUPP;
            else if (!hart_halted) cmderr_d = ERR_HALTRES;
            else if (cmd_word[17]) state_d  = CMD_REQ;
        end

        // Register bus handshake; ack capture overrides any DMI data0 update.
        case (state_q)
            CMD_REQ: begin
                if (dbg_reg_ack) begin
                    if (!cmd_we_q) data0_d = dbg_reg_rdata;
                    state_d = CMD_DONE;
                end
            end
            CMD_DONE: state_d = CMD_IDLE;
            default:  ;
        endcase

        // Inactive DM: everything but dmactive is held in reset, aborting commands.
        if (!dmactive_d) begin
            state_d     = CMD_IDLE;
            haltreq_d   = 1'b0;
            ndmreset_d  = 1'b0;
            resume_d    = 1'b0;
            resumeack_d = 1'b0;
            data0_d     = '0;
            cmderr_d    = ERR_NONE;
            cmd_we_d    = 1'b0;
            cmd_regno_d = '0;
`ifdef RAIFES_DM_AUTOEXEC_EN
            autoexec_d  = 1'b0;
            cmd_last_d  = '0;
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CMD_IDLE;
            dmactive_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            ndmreset_q  <= 1'b0;
            resume_q    <= 1'b0;
            resumeack_q <= 1'b0;
            data0_q     <= '0;
            cmderr_q    <= ERR_NONE;
            cmd_we_q    <= 1'b0;
            cmd_regno_q <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
`ifdef RAIFES_DM_AUTOEXEC_EN
            autoexec_q  <= 1'b0;
            cmd_last_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dmactive_q  <= dmactive_d;
            haltreq_q   <= haltreq_d;
            ndmreset_q  <= ndmreset_d;
            resume_q    <= resume_d;
            resumeack_q <= resumeack_d;
            data0_q     <= data0_d;
            cmderr_q    <= cmderr_d;
            cmd_we_q    <= cmd_we_d;
            cmd_regno_q <= cmd_regno_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
`ifdef RAIFES_DM_AUTOEXEC_EN
            autoexec_q  <= autoexec_d;
            cmd_last_q  <= cmd_last_d;
`endif
        end
    end

    assign dmi_rdata     = rdata_q;
    assign dmi_error     = error_q;
    assign dmi_dm_busy   = busy;
    assign ndmreset      = ndmreset_q;
    assign halt_req      = haltreq_q & dmactive_q;
    assign resume_req    = resume_q;
    assign dbg_reg_req   = busy;
    assign dbg_reg_we    = busy & cmd_we_q;
    assign dbg_reg_addr  = cmd_regno_q;
    assign dbg_reg_wdata = data0_q;

endmodule

// File: tb/tb_raifes_dm.sv
// Directed bench for raifes_dm: DMI decode, halt/resume, abstract commands.
module tb_raifes_dm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic        dmi_en;
    logic        dmi_wen;
    logic [31:0] dmi_rdata;
    logic        dmi_error;
    logic        dmi_dm_busy;
    logic        ndmreset;
    logic        halt_req;
    logic        resume_req;
    logic        hart_halted;
    logic        dbg_reg_req;
    logic        dbg_reg_we;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_wdata;
    logic [31:0] dbg_reg_rdata;
    logic        dbg_reg_ack;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd;

    raifes_dm dut (
        .clk(clk), .reset_n(reset_n),
        .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_en(dmi_en), .dmi_wen(dmi_wen),
        .dmi_rdata(dmi_rdata), .dmi_error(dmi_error), .dmi_dm_busy(dmi_dm_busy),
        .ndmreset(ndmreset), .halt_req(halt_req), .resume_req(resume_req),
        .hart_halted(hart_halted),
        .dbg_reg_req(dbg_reg_req), .dbg_reg_we(dbg_reg_we), .dbg_reg_addr(dbg_reg_addr),
        .dbg_reg_wdata(dbg_reg_wdata), .dbg_reg_rdata(dbg_reg_rdata), .dbg_reg_ack(dbg_reg_ack)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle DMI strobe; returns on the negedge after the sampling posedge.
    task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
        tick();
        dmi_addr = a; dmi_wdata = d; dmi_wen = 1'b1; dmi_en = 1'b1;
        tick();
        dmi_en = 1'b0; dmi_wen = 1'b0;
    endtask

    task automatic dmi_rd(input logic [6:0] a, output logic [31:0] d);
        tick();
        dmi_addr = a; dmi_wdata = '0; dmi_wen = 1'b0; dmi_en = 1'b1;
        tick();
        dmi_en = 1'b0;
        d = dmi_rdata;
    endtask

    // Single-cycle ack pulse with read data.
    task automatic ack(input logic [31:0] d);
        dbg_reg_rdata = d; dbg_reg_ack = 1'b1;
        tick();
        dbg_reg_ack = 1'b0; dbg_reg_rdata = '0;
    endtask

    initial begin
        reset_n = 1'b0; dmi_addr = '0; dmi_wdata = '0; dmi_en = 1'b0; dmi_wen = 1'b0;
        hart_halted = 1'b0; dbg_reg_rdata = '0; dbg_reg_ack = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_outs", {dmi_rdata[7:0], 2'b0, dmi_error, dmi_dm_busy, ndmreset, halt_req,
                         resume_req, dbg_reg_req, dbg_reg_we, dbg_reg_addr}, 32'h0);
        chk("rst_rdata", dmi_rdata, 32'h0);
        chk("rst_wdata", dbg_reg_wdata, 32'h0);

        // dmstatus while inactive, unknown addresses, hartinfo
        dmi_rd(7'h11, rd);  chk("dmstatus_rst", rd, 32'h0000_0082);
        chk("dmstatus_err", {31'd0, dmi_error}, 32'h0);
        dmi_rd(7'h05, rd);  chk("unk_rd", rd, 32'h0);
        chk("unk_err", {31'd0, dmi_error}, 32'h1);
        dmi_rd(7'h12, rd);  chk("hartinfo", rd, 32'h0);
        chk("hartinfo_err", {31'd0, dmi_error}, 32'h0);
        dmi_rd(7'h18, rd);
`ifdef RAIFES_DM_AUTOEXEC_EN
        chk("auto_err", {31'd0, dmi_error}, 32'h0);
`else
        chk("auto_err", {31'd0, dmi_error}, 32'h1);
`endif

        // Halt request
        dmi_wr(7'h10, 32'h8000_0001);
        chk("halt_req", {31'd0, halt_req}, 32'h1);
        hart_halted = 1'b1;
        dmi_rd(7'h11, rd);  chk("dmstatus_halted", rd, 32'h0000_0382);
        dmi_rd(7'h10, rd);  chk("dmcontrol_rd", rd, 32'h8000_0001);

        // Abstract write of x5, ack after 3 cycles
        dmi_wr(7'h04, 32'hDEAD_BEEF);
        dmi_wr(7'h17, 32'h0023_1005);
        chk("wr_req", {dbg_reg_req, dbg_reg_we, dmi_dm_busy, dbg_reg_addr}, {3'b111, 5'd5});
        chk("wr_wdata", dbg_reg_wdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_req_hold", {31'd0, dbg_reg_req}, 32'h1);
        end
        ack(32'h0);
        chk("wr_done", {30'd0, dmi_dm_busy, dbg_reg_req}, 32'h0);
        dmi_rd(7'h16, rd);  chk("acs_after_wr", rd, 32'h0000_0001);

        // Abstract read of x7, busy-violations while pending
        dmi_wr(7'h17, 32'h0022_1007);
        chk("rd_req", {dbg_reg_req, dbg_reg_we, dmi_dm_busy, dbg_reg_addr}, {3'b101, 5'd7});
        dmi_rd(7'h04, rd);  chk("data0_busy_rd", rd, 32'hDEAD_BEEF);
        dmi_wr(7'h04, 32'hAAAA_AAAA);
        ack(32'h1234_5678);
        chk("rd_done", {31'd0, dmi_dm_busy}, 32'h0);
        dmi_rd(7'h04, rd);  chk("data0_capt", rd, 32'h1234_5678);
        dmi_rd(7'h16, rd);  chk("acs_busyerr", rd, 32'h0000_0101);
        dmi_wr(7'h17, 32'h0023_1005);
        chk("cmd_blocked", {31'd0, dbg_reg_req}, 32'h0);
        dmi_wr(7'h16, 32'h0000_0700);
        dmi_rd(7'h16, rd);  chk("acs_clr", rd, 32'h0000_0001);

        // Unsupported regno, running hart, transfer=0
        dmi_wr(7'h17, 32'h0022_0300);
        chk("unsupp_noreq", {31'd0, dbg_reg_req}, 32'h0);
        dmi_rd(7'h16, rd);  chk("acs_err2", rd, 32'h0000_0201);
        dmi_wr(7'h16, 32'h0000_0700);
        hart_halted = 1'b0;
        dmi_wr(7'h17, 32'h0022_1007);
        chk("running_noreq", {31'd0, dbg_reg_req}, 32'h0);
        dmi_rd(7'h16, rd);  chk("acs_err4", rd, 32'h0000_0401);
        dmi_wr(7'h16, 32'h0000_0700);
        hart_halted = 1'b1;
        dmi_wr(7'h17, 32'h0020_1000);
        chk("notransfer_noreq", {31'd0, dbg_reg_req}, 32'h0);
        dmi_rd(7'h16, rd);  chk("acs_notransfer", rd, 32'h0000_0001);

        // Resume: hart leaves debug mode 4 cycles later
        dmi_wr(7'h10, 32'h4000_0001);
        chk("resume_set", {30'd0, resume_req, halt_req}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("resume_hold", {31'd0, resume_req}, 32'h1);
        end
        hart_halted = 1'b0;
        tick();
        chk("resume_clr", {31'd0, resume_req}, 32'h0);
        dmi_rd(7'h11, rd);  chk("dmstatus_resumed", rd, 32'h0003_0C82);
        dmi_rd(7'h10, rd);  chk("dmcontrol_nores", rd, 32'h0000_0001);

        // ndmreset
        dmi_wr(7'h10, 32'h0000_0003);
        chk("ndmreset_on", {31'd0, ndmreset}, 32'h1);
        dmi_wr(7'h10, 32'h0000_0001);
        chk("ndmreset_off", {31'd0, ndmreset}, 32'h0);

        // dmactive=0 aborts an in-flight command
        hart_halted = 1'b1;
        dmi_wr(7'h17, 32'h0023_1005);
        chk("abort_req_on", {31'd0, dbg_reg_req}, 32'h1);
        dmi_wr(7'h10, 32'h0000_0000);
        chk("abort_req_off", {30'd0, dbg_reg_req, dmi_dm_busy}, 32'h0);
        dmi_rd(7'h04, rd);  chk("inactive_data0", rd, 32'h0);
        dmi_wr(7'h04, 32'h0000_0055);
        dmi_rd(7'h04, rd);  chk("inactive_wr_ign", rd, 32'h0);
        dmi_rd(7'h10, rd);  chk("inactive_dmcontrol", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
